// File: rtl/vector_player_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_player_pkg : shared types and constants for the vector player     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vector_player_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } vp_state_e;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned DRAIN_CNT_W = 4;

  // DRAIN lasts LATENCY cycles, but never less than one.
  function automatic logic [DRAIN_CNT_W-1:0] drain_last(input int unsigned latency);
    return DRAIN_CNT_W'((latency == 0) ? 0 : latency - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_player_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vp_delay_line : STAGES-deep reset-able shift register, wire if STAGES=0  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vp_delay_line
  import vector_player_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 0
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (STAGES == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clock_i ^ reset_i;
      assign q_o      = d_i;
    end else begin : g_pipe
      logic [W-1:0] stage_q [STAGES];

      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vector_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_player : plays a stored vector table and checks DUT responses     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vector_player
  import vector_player_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int RESP_W  = 1,
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_stim_i,
  input  logic [RESP_W-1:0] wr_exp_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic              loop_en_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [RESP_W-1:0] resp_mask_i,
  input  logic [RESP_W-1:0] dut_resp_i,
  output logic [WIDTH-1:0]  stim_out_o,
  output logic              stim_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] vector_idx_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o,
  output logic              fail_seen_o,
  output logic [ADDR_W-1:0] first_fail_o
);

  localparam int                     DL_W       = 1 + ADDR_W + RESP_W;
  localparam logic [ADDR_W:0]        DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]       CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = drain_last(LATENCY);

  logic [WIDTH+RESP_W-1:0] table_q [DEPTH];

  vp_state_e               state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [ADDR_W:0]         len_q;
  logic                    loop_q;
  logic [DRAIN_CNT_W-1:0]  drain_q;
  logic [WIDTH-1:0]        stim_q;
  logic [RESP_W-1:0]       exp_q;
  logic                    stim_valid_q;
  logic [ADDR_W-1:0]       vector_idx_q;
  logic                    busy_q;
  logic                    done_q;
  logic [CNT_W-1:0]        mismatch_cnt_q;
  logic [CNT_W-1:0]        mismatch_cnt_d;
  logic                    fail_seen_q;
  logic [ADDR_W-1:0]       first_fail_q;

  logic                    w_can_start;
  logic                    w_start_ok;
  logic                    w_wr_ok;
  logic                    w_last;
  logic [ADDR_W:0]         w_len;
  logic [DL_W-1:0]         w_dl_in;
  logic [DL_W-1:0]         w_dl_out;
  logic                    w_chk_valid;
  logic [ADDR_W-1:0]       w_chk_idx;
  logic [RESP_W-1:0]       w_chk_exp;
  logic                    w_mismatch;

  assign w_can_start = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_start_ok  = start_i && w_can_start;
  assign w_wr_ok     = wr_en_i && w_can_start && ({1'b0, wr_addr_i} < DEPTH_L);
  assign w_len       = (length_i > DEPTH_L) ? DEPTH_L : length_i;
  assign w_last      = (({1'b0, idx_q} + (ADDR_W+1)'(1)) == len_q);

  // A write in the same cycle as start lands before the first table read.
  always_ff @(posedge clock_i) begin
    if (w_wr_ok) table_q[wr_addr_i] <= {wr_stim_i, wr_exp_i};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      drain_q      <= '0;
      stim_q       <= '0;
      exp_q        <= '0;
      stim_valid_q <= 1'b0;
      vector_idx_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          stim_valid_q <= 1'b0;
          if (start_i) begin
            len_q  <= w_len;
            loop_q <= loop_en_i;
            idx_q  <= '0;
            if (w_len == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          {stim_q, exp_q} <= table_q[idx_q];
          stim_valid_q    <= 1'b1;
          vector_idx_q    <= idx_q;
          if (stop_i || (w_last && !loop_q)) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end else if (w_last) begin
            idx_q <= '0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          stim_valid_q <= 1'b0;
          if (drain_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w_dl_in = {stim_valid_q, vector_idx_q, exp_q};

  vp_delay_line #(
    .W      (DL_W),
    .STAGES (LATENCY)
  ) u_delay (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (w_dl_in),
    .q_o     (w_dl_out)
  );

  assign {w_chk_valid, w_chk_idx, w_chk_exp} = w_dl_out;
  assign w_mismatch = w_chk_valid && (((dut_resp_i ^ w_chk_exp) & resp_mask_i) != '0);

  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    if (mismatch_cnt_q != CNT_SAT) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || w_start_ok) begin
      mismatch_cnt_q <= '0;
      fail_seen_q    <= 1'b0;
      first_fail_q   <= '0;
    end else if (w_mismatch) begin
      mismatch_cnt_q <= mismatch_cnt_d;
      fail_seen_q    <= 1'b1;
      if (!fail_seen_q) first_fail_q <= w_chk_idx;
    end
  end

  assign stim_out_o     = stim_q;
  assign stim_valid_o   = stim_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign vector_idx_o   = vector_idx_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign fail_seen_o    = fail_seen_q;
  assign first_fail_o   = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_player : randomized bench for vector_player with a lab DUT     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vector_player;

  localparam int WIDTH     = 4;
  localparam int RESP_W    = 2;
  localparam int DEPTH     = 12;
  localparam int ADDR_W    = 4;
  localparam int LATENCY   = 2;
  localparam int CNT_W     = 3;
  localparam int DRAIN_CYC = (LATENCY == 0) ? 1 : LATENCY;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_stim;
  logic [RESP_W-1:0] wr_exp;
  logic [ADDR_W:0]   length;
  logic              loop_en;
  logic              start;
  logic              stop;
  logic [RESP_W-1:0] resp_mask;
  logic [RESP_W-1:0] dut_resp;
  logic [WIDTH-1:0]  stim_out;
  logic              stim_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] vector_idx;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic              fail_seen;
  logic [ADDR_W-1:0] first_fail;

  int n_total = 0;
  int n_bad   = 0;

  logic [WIDTH-1:0]  tb_stim [DEPTH];
  logic [RESP_W-1:0] tb_exp  [DEPTH];
  logic [WIDTH-1:0]  last_stim;
  int                last_idx;

  always #5 clk = ~clk;

  vector_player #(
    .WIDTH   (WIDTH),
    .RESP_W  (RESP_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_stim_i      (wr_stim),
    .wr_exp_i       (wr_exp),
    .length_i       (length),
    .loop_en_i      (loop_en),
    .start_i        (start),
    .stop_i         (stop),
    .resp_mask_i    (resp_mask),
    .dut_resp_i     (dut_resp),
    .stim_out_o     (stim_out),
    .stim_valid_o   (stim_valid),
    .busy_o         (busy),
    .done_o         (done),
    .vector_idx_o   (vector_idx),
    .mismatch_cnt_o (mismatch_cnt),
    .fail_seen_o    (fail_seen),
    .first_fail_o   (first_fail)
  );

  function automatic logic [RESP_W-1:0] lab_f(input logic [WIDTH-1:0] s);
    return s[1:0] ^ s[3:2];
  endfunction

  // Lab DUT: LATENCY-stage registered pipeline computing lab_f.
  logic [RESP_W-1:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= lab_f(stim_out);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign dut_resp = pipe[LATENCY-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic write_entry(input int a, input logic [WIDTH-1:0] s, input logic [RESP_W-1:0] e);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_stim = s; wr_exp = e;
    @(negedge clk);
    wr_en = 1'b0;
    tb_stim[a] = s;
    tb_exp[a]  = e;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stim_out"},     stim_out,     0);
    check({tag, ".stim_valid"},   stim_valid,   0);
    check({tag, ".busy"},         busy,         0);
    check({tag, ".done"},         done,         0);
    check({tag, ".vector_idx"},   vector_idx,   0);
    check({tag, ".mismatch_cnt"}, mismatch_cnt, 0);
    check({tag, ".fail_seen"},    fail_seen,    0);
    check({tag, ".first_fail"},   first_fail,   0);
  endtask

  // stop_at < 0: stop is asserted together with start (must be ignored).
  task automatic run_trial(input int len, input bit lp, input int stop_at,
                           input logic [RESP_W-1:0] mask, input bit wr_in_run,
                           input bit wr_at_start);
    int lc, issued, nmis, first_idx, idx, ncyc;
    lc = (len > DEPTH) ? DEPTH : len;
    length = (ADDR_W+1)'(len); loop_en = lp; resp_mask = mask;
    start = 1'b1; stop = (stop_at < 0);
    if (wr_at_start) begin
      wr_en = 1'b1; wr_addr = '0;
      wr_stim = WIDTH'($urandom); wr_exp = RESP_W'($urandom);
      tb_stim[0] = wr_stim; tb_exp[0] = wr_exp;
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;

    if (lc == 0) issued = 0;
    else if (stop_at >= 0 && (lp || stop_at + 1 < lc)) issued = stop_at + 1;
    else issued = lc;

    if (lc == 0) begin
      check("len0.done", done, 1);
      check("len0.busy", busy, 0);
      check("len0.mismatch_cnt", mismatch_cnt, 0);
      check("len0.fail_seen", fail_seen, 0);
      repeat (2) begin
        check("len0.stim_valid", stim_valid, 0);
        @(negedge clk);
      end
      return;
    end

    ncyc = issued + DRAIN_CYC + 3;
    for (int c = 0; c <= ncyc; c++) begin
      if (c >= 1) begin
        if (c <= issued) begin
          idx       = (c - 1) % lc;
          last_idx  = idx;
          last_stim = tb_stim[idx];
          check("stim_valid", stim_valid, 1);
        end else begin
          check("stim_valid", stim_valid, 0);
        end
        check("vector_idx", vector_idx, last_idx);
        check("stim_out", stim_out, last_stim);
        check("done", done, (c >= issued + DRAIN_CYC));
        check("busy", busy, (c < issued + DRAIN_CYC));
      end
      stop  = (c == stop_at);
      wr_en = wr_in_run && (c < issued + DRAIN_CYC);
      if (wr_en) begin
        wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        wr_stim = WIDTH'($urandom);
        wr_exp  = RESP_W'($urandom);
      end
      @(negedge clk);
    end
    stop = 1'b0; wr_en = 1'b0;

    nmis = 0; first_idx = 0;
    for (int j = 0; j < issued; j++) begin
      idx = j % lc;
      if (((lab_f(tb_stim[idx]) ^ tb_exp[idx]) & mask) != '0) begin
        if (nmis == 0) first_idx = idx;
        nmis++;
      end
    end
    check("mismatch_cnt", mismatch_cnt, (nmis > CNT_MAX) ? CNT_MAX : nmis);
    check("fail_seen", fail_seen, (nmis != 0));
    check("first_fail", first_fail, first_idx);
  endtask

  initial begin
    int len, sa;
    bit lp;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_stim = '0; wr_exp = '0;
    length = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; resp_mask = '0;
    last_stim = '0; last_idx = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) begin
      logic [WIDTH-1:0] s;
      s = WIDTH'($urandom);
      write_entry(a, s, ($urandom_range(0, 2) == 0) ? RESP_W'($urandom) : lab_f(s));
    end

    run_trial(4,  0, 1000, 2'b11, 0, 0);
    run_trial(DEPTH, 0, 1000, 2'b11, 0, 0);
    run_trial(20, 0, 1000, 2'b11, 0, 0);
    run_trial(0,  0, 1000, 2'b11, 0, 0);
    run_trial(3,  1, 9,    2'b11, 0, 0);
    run_trial(7,  0, 3,    2'b11, 0, 0);
    run_trial(6,  0, -1,   2'b11, 0, 0);
    run_trial(6,  0, 1000, 2'b01, 0, 0);
    run_trial(6,  0, 1000, 2'b00, 0, 0);
    run_trial(8,  0, 1000, 2'b11, 1, 0);
    run_trial(8,  0, 1000, 2'b11, 0, 0);
    run_trial(5,  0, 1000, 2'b11, 0, 1);

    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(0, DEPTH + 3);
      lp  = 1'($urandom_range(0, 1));
      if (lp) sa = $urandom_range(0, 20);
      else sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH) : 1000;
      run_trial(len, lp, sa, RESP_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int a = 0; a < DEPTH; a++) write_entry(a, tb_stim[a], ~lab_f(tb_stim[a]));
    run_trial(5, 1, 10, 2'b11, 0, 0);
    run_trial(8, 0, 1000, 2'b11, 0, 0);

    length = 5'd8; loop_en = 1'b1; resp_mask = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrun_reset");
    last_stim = '0; last_idx = 0;
    repeat (6) @(negedge clk);
    check_all_zero("after_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
